// File: rtl/param_serial_alu.sv
// rtl/param_serial_alu.sv - subword-serial integer execute unit with val/rdy request and response ports
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_val      request valid
//   req_rdy      request ready (high only in IDLE)
//   req_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10-15 illegal
//   req_a        operand A
//   req_b        operand B; shifts use req_b[4:0] as the shift amount
//   resp_val     response valid
//   resp_rdy     response ready
//   resp_result  result, held stable while resp_val is high
//   busy         high whenever the unit is not in IDLE
//
// Optional feature macro: PARAM_SERIAL_ALU_FAST_SHIFT_EN
//   defined   : shifts move min(remaining, P_NBITS) bits per cycle
//   undefined : shifts move one bit per cycle
module param_serial_alu #(
    parameter int P_NBITS = 4,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_val,
    output logic            req_rdy,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_val,
    input  logic            resp_rdy,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam int C_N_OFF   = XLEN / P_NBITS;
    localparam int C_OFFBITS = (C_N_OFF > 1) ? $clog2(C_N_OFF) : 1;
    localparam int C_SHW     = $clog2(XLEN);
    // One extra bit so the counter can hold P_NBITS itself as a step size.
    localparam int C_CNTW    = C_SHW + 1;

    localparam logic [C_OFFBITS-1:0] C_LAST = C_OFFBITS'(C_N_OFF - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [3:0]            op_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [XLEN-1:0]       res_q;
    logic                  carry_q;
    logic [C_OFFBITS-1:0]  off_q;
    logic [C_CNTW-1:0]     sh_cnt_q;

    logic [P_NBITS-1:0]    a_sub;
    logic [P_NBITS-1:0]    b_sub;
    logic [P_NBITS-1:0]    b_eff;
    logic [P_NBITS-1:0]    sub_res;
    logic [P_NBITS:0]      sum;
    logic                  signed_lt;
    logic                  unsigned_lt;
    logic                  last_sub;
    logic [XLEN-1:0]       res_shifted;
    logic [XLEN-1:0]       exec_res;
    logic [XLEN-1:0]       sh_res;
    logic [C_CNTW-1:0]     sh_step;
    logic [C_CNTW-1:0]     sh_cnt_next;

    // Subtract-style ops run a + ~b with the carry seeded to 1.
    function automatic logic uses_borrow(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Subword datapath: one P_NBITS slice per EXEC cycle, LSB first.
    always_comb begin
        a_sub    = a_q[int'(off_q) * P_NBITS +: P_NBITS];
        b_sub    = b_q[int'(off_q) * P_NBITS +: P_NBITS];
        b_eff    = uses_borrow(op_q) ? ~b_sub : b_sub;
        sum      = {1'b0, a_sub} + {1'b0, b_eff} + {{P_NBITS{1'b0}}, carry_q};
        last_sub = (off_q == C_LAST);
        case (op_q)
            OP_AND:  sub_res = a_sub & b_sub;
            OP_OR:   sub_res = a_sub | b_sub;
            OP_XOR:  sub_res = a_sub ^ b_sub;
            default: sub_res = sum[P_NBITS-1:0];
        endcase
        // Only meaningful on the final subword, where sum holds the top
        // bits of a - b and its carry out.
        signed_lt   = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? a_q[XLEN-1] : sum[P_NBITS-1];
        unsigned_lt = ~sum[P_NBITS];
    end

    // New subwords enter at the MSB end so after C_N_OFF steps the first
    // subword has reached bit 0.
    generate
        if (P_NBITS == XLEN) begin : g_full_word
            assign res_shifted = sub_res;
        end else begin : g_sub_word
            assign res_shifted = {sub_res, res_q[XLEN-1:P_NBITS]};
        end
    endgenerate

    always_comb begin
        exec_res = res_shifted;
        if (last_sub && (op_q == OP_SLT)) begin
            exec_res = {{(XLEN-1){1'b0}}, signed_lt};
        end else if (last_sub && (op_q == OP_SLTU)) begin
            exec_res = {{(XLEN-1){1'b0}}, unsigned_lt};
        end
    end

    // Shift datapath. A zero count leaves the working value untouched, which
    // gives the one-cycle pass-through for shamt == 0.
    always_comb begin
`ifdef PARAM_SERIAL_ALU_FAST_SHIFT_EN
        sh_step = (sh_cnt_q > C_CNTW'(P_NBITS)) ? C_CNTW'(P_NBITS) : sh_cnt_q;
        case (op_q)
            OP_SLL:  sh_res = res_q << sh_step;
            OP_SRL:  sh_res = res_q >> sh_step;
            // The working value starts as a, so its MSB is a[XLEN-1] throughout.
            default: sh_res = $unsigned($signed(res_q) >>> sh_step);
        endcase
`else
        sh_step = (sh_cnt_q != '0) ? C_CNTW'(1) : '0;
        if (sh_cnt_q == '0) begin
            sh_res = res_q;
        end else begin
            case (op_q)
                OP_SLL:  sh_res = {res_q[XLEN-2:0], 1'b0};
                OP_SRL:  sh_res = {1'b0, res_q[XLEN-1:1]};
                default: sh_res = {a_q[XLEN-1], res_q[XLEN-1:1]};
            endcase
        end
`endif
        sh_cnt_next = sh_cnt_q - sh_step;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            off_q    <= '0;
            sh_cnt_q <= '0;
            req_rdy  <= 1'b1;
            resp_val <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_val) begin
                        op_q     <= req_op;
                        a_q      <= req_a;
                        b_q      <= req_b;
                        off_q    <= '0;
                        carry_q  <= uses_borrow(req_op);
                        sh_cnt_q <= C_CNTW'(req_b[C_SHW-1:0]);
                        res_q    <= is_shift(req_op) ? req_a : '0;
                        req_rdy  <= 1'b0;
                        busy     <= 1'b1;
                        if (req_op <= OP_SLTU) begin
                            state_q <= S_EXEC;
                        end else if (is_shift(req_op)) begin
                            state_q <= S_SHIFT;
                        end else begin
                            state_q  <= S_DONE;
                            resp_val <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    res_q   <= exec_res;
                    carry_q <= sum[P_NBITS];
                    off_q   <= off_q + 1'b1;
                    if (last_sub) begin
                        state_q  <= S_DONE;
                        resp_val <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    res_q    <= sh_res;
                    sh_cnt_q <= sh_cnt_next;
                    if (sh_cnt_next == '0) begin
                        state_q  <= S_DONE;
                        resp_val <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_rdy) begin
                        state_q  <= S_IDLE;
                        resp_val <= 1'b0;
                        req_rdy  <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    resp_val <= 1'b0;
                    req_rdy  <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign resp_result = res_q;

endmodule

// File: tb/tb_param_serial_alu.sv
// tb/tb_param_serial_alu.sv - bench for param_serial_alu at P_NBITS = 1, 4, 8, 32
module tb_param_serial_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_rdy;

    logic [3:0]  req_rdy_w;
    logic [3:0]  resp_val_w;
    logic [3:0]  busy_w;
    logic [31:0] resp_result_w [4];

    int checks = 0;
    int errors = 0;

    logic [3:0]  pending   = '0;
    logic [3:0]  responded = '0;
    logic [31:0] exp_res [4];
    logic [31:0] got_res [4];
    int          exp_lat [4];
    int          got_lat [4];
    int          cnt     [4];
    int          pnb     [4] = '{1, 4, 8, 32};

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int PN = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
            param_serial_alu #(.P_NBITS(PN), .XLEN(32)) u_dut (
                .clk         (clk),
                .reset       (reset),
                .req_val     (req_val),
                .req_rdy     (req_rdy_w[g]),
                .req_op      (req_op),
                .req_a       (req_a),
                .req_b       (req_b),
                .resp_val    (resp_val_w[g]),
                .resp_rdy    (resp_rdy),
                .resp_result (resp_result_w[g]),
                .busy        (busy_w[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Rising edges after the accepting edge until resp_val is first seen.
    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b, input int p);
        int sh;
        sh = int'(b[4:0]);
        if (op <= 4'd6) return 32 / p;
        if (op <= 4'd9) begin
            if (sh == 0) return 1;
`ifdef PARAM_SERIAL_ALU_FAST_SHIFT_EN
            return (sh + p - 1) / p;
`else
            return sh;
`endif
        end
        return 0;
    endfunction

    // Single compare process: every DUT checked on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset) begin
                chk("rst_resp_val", i, 32'(resp_val_w[i]), 32'd0);
                chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
                chk("rst_result", i, resp_result_w[i], 32'd0);
                pending[i] = 1'b0;
            end else if (pending[i]) begin
                cnt[i]++;
                chk("busy_hi", i, 32'(busy_w[i]), 32'd1);
                chk("req_rdy_lo", i, 32'(req_rdy_w[i]), 32'd0);
                if (resp_val_w[i]) begin
                    chk("result", i, resp_result_w[i], exp_res[i]);
                    if (!responded[i]) begin
                        chk("latency", i, cnt[i], exp_lat[i]);
                        got_res[i]   = resp_result_w[i];
                        got_lat[i]   = cnt[i];
                        responded[i] = 1'b1;
                    end
                    if (resp_rdy) pending[i] = 1'b0;
                end else if (responded[i]) begin
                    chk("resp_dropped", i, 32'(resp_val_w[i]), 32'd1);
                    pending[i] = 1'b0;
                end else if (cnt[i] > exp_lat[i]) begin
                    chk("resp_late", i, cnt[i], exp_lat[i]);
                    pending[i] = 1'b0;
                end
            end else begin
                chk("idle_resp_val", i, 32'(resp_val_w[i]), 32'd0);
                chk("idle_busy", i, 32'(busy_w[i]), 32'd0);
                chk("idle_req_rdy", i, 32'(req_rdy_w[i]), 32'd1);
                if (req_val && req_rdy_w[i]) begin
                    exp_res[i]   = model_result(req_op, req_a, req_b);
                    exp_lat[i]   = model_lat(req_op, req_b, pnb[i]);
                    got_res[i]   = 'x;
                    got_lat[i]   = -1;
                    cnt[i]       = -1;
                    pending[i]   = 1'b1;
                    responded[i] = 1'b0;
                end
            end
        end
    end

    // Called #1 after a rising edge; presents the request for one cycle and
    // then scrambles the operand inputs.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op  = op;
        req_a   = a;
        req_b   = b;
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        req_op  = 4'($urandom);
        req_a   = $urandom;
        req_b   = $urandom;
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        n = 0;
        while (pending != 4'b0 && n < 300) begin
            @(posedge clk);
            #1;
            if (rnd) resp_rdy = ($urandom_range(0, 3) != 0);
            n++;
        end
        chk("wait_idle", 0, 32'(pending), 32'd0);
        resp_rdy = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        send(op, a, b);
        wait_idle(1'b0);
    endtask

    task automatic check_all(input string name, input logic [31:0] r, input int l0, input int l1, input int l2, input int l3);
        int l [4];
        l = '{l0, l1, l2, l3};
        for (int i = 0; i < 4; i++) begin
            chk({name, "_res"}, i, got_res[i], r);
            chk({name, "_lat"}, i, got_lat[i], l[i]);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int r;

        reset    = 1'b0;
        req_val  = 1'b0;
        req_op   = '0;
        req_a    = '0;
        req_b    = '0;
        resp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Pin the reference model with hand-computed values.
        chk("model_add", -1, model_result(4'd0, 32'hFFFF_FFFF, 32'h1), 32'h0);
        chk("model_sra", -1, model_result(4'd9, 32'h8000_0000, 32'd4), 32'hF800_0000);
        chk("model_slt", -1, model_result(4'd5, 32'h8000_0000, 32'd1), 32'd1);
        chk("model_lat", -1, model_lat(4'd0, 32'd0, 1), 32'd32);

        do_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        check_all("add_carry", 32'h0000_0000, 32, 8, 4, 1);
        do_op(4'd1, 32'd5, 32'd7);
        check_all("sub", 32'hFFFF_FFFE, 32, 8, 4, 1);
        do_op(4'd5, 32'h8000_0000, 32'd1);
        check_all("slt", 32'h0000_0001, 32, 8, 4, 1);
        do_op(4'd6, 32'h8000_0000, 32'd1);
        check_all("sltu", 32'h0000_0000, 32, 8, 4, 1);
        do_op(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check_all("and", 32'h00F0_00F0, 32, 8, 4, 1);
        do_op(4'd9, 32'h8000_0000, 32'd4);
`ifdef PARAM_SERIAL_ALU_FAST_SHIFT_EN
        check_all("sra4", 32'hF800_0000, 4, 1, 1, 1);
`else
        check_all("sra4", 32'hF800_0000, 4, 4, 4, 4);
`endif
        do_op(4'd7, 32'h1234_5678, 32'hFFFF_FFE0);
        check_all("sll0", 32'h1234_5678, 1, 1, 1, 1);
        do_op(4'd12, 32'h1, 32'h2);
        check_all("illegal", 32'h0000_0000, 0, 0, 0, 0);

        // Backpressure: hold the response, pulse a request that must be ignored.
        resp_rdy = 1'b0;
        send(4'd0, 32'd10, 32'd20);
        n = 0;
        while (responded != 4'hF && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_all_responded", 0, 32'(responded), 32'hF);
        @(posedge clk);
        #1;
        req_op  = 4'd4;
        req_a   = 32'hDEAD_BEEF;
        req_b   = 32'h1234_5678;
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        check_all("bp", 32'd30, 32, 8, 4, 1);
        send(4'd0, 32'd7, 32'd8);
        chk("bp_next_accept", 0, 32'(pending), 32'hF);
        wait_idle(1'b0);
        check_all("bp_next", 32'd15, 32, 8, 4, 1);

        // Reset in the middle of EXEC (subword 3 at P_NBITS=4).
        send(4'd0, 32'h1234_5678, 32'h1111_1111);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_resp_val", i, 32'(resp_val_w[i]), 32'd0);
            chk("abort_busy", i, 32'(busy_w[i]), 32'd0);
            chk("abort_result", i, resp_result_w[i], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op(4'd0, 32'd2, 32'd3);
        check_all("after_rst", 32'd5, 32, 8, 4, 1);

        // Randomized traffic with random response backpressure.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 19);
            if (r < 10)      op = 4'(r);
            else if (r < 17) op = 4'($urandom_range(0, 9));
            else             op = 4'($urandom_range(10, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: b = a;
                2: b = 32'h8000_0000;
                default: ;
            endcase
            send(op, a, b);
            wait_idle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
